// File: rtl/hsv_core_pkg.sv
// Shared core types: register/word aliases and the commit-stage payload and unit enumeration.
package hsv_core_pkg;

  typedef logic [4:0]  reg_addr;
  typedef logic [31:0] word;

  typedef struct packed {
    reg_addr rd_addr;
    word     rd_value;
    logic    writeback;
    logic    flush;
    word     flush_pc;
  } commit_data_t;

  localparam int unsigned COMMIT_UNITS = 4;

  typedef enum logic [1:0] {
    COMMIT_ALU,
    COMMIT_BRANCH,
    COMMIT_CTRL_STATUS,
    COMMIT_MEM
  } commit_unit_t;

endpackage

// File: rtl/hsv_core_commit_arbiter.sv
// N-way arbiter with one-hot grant; round-robin from a registered pointer or fixed priority (index 0 highest).
module hsv_core_commit_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned RR = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] base;
  logic [PW-1:0] gidx;
  logic          found;
  int unsigned   idx;

  assign base = (RR != 0) ? ptr : '0;

  // Scan starts at the pointer and wraps, so the unit after the last winner has top priority.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(base) + i;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx[PW-1:0]]) begin
        found                = 1'b1;
        grant[idx[PW-1:0]]   = 1'b1;
        gidx                 = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (RR != 0 && found) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/hsv_core_commit.sv
// Writeback/commit stage: picks one completed result per cycle, writes the register file, releases the scoreboard, raises flushes.
module hsv_core_commit
  import hsv_core_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned RR_ARB   = 1
) (
  input  logic                clk_core,
  input  logic                rst_core,
  input  logic                alu_valid_i,
  input  logic                branch_valid_i,
  input  logic                ctrl_status_valid_i,
  input  logic                mem_valid_i,
  input  commit_data_t        alu_result,
  input  commit_data_t        branch_result,
  input  commit_data_t        ctrl_status_result,
  input  commit_data_t        mem_result,
  output logic                alu_ready_o,
  output logic                branch_ready_o,
  output logic                ctrl_status_ready_o,
  output logic                mem_ready_o,
  output logic                wr_en,
  output logic [4:0]          wr_addr,
  output logic [XLEN-1:0]     wr_data,
  output logic [NUM_REGS-1:0] commit_mask,
  output logic                retire,
  output logic                flush_req,
  output logic [XLEN-1:0]     flush_pc
);

  logic [COMMIT_UNITS-1:0] valid;
  logic [COMMIT_UNITS-1:0] grant;
  commit_data_t            results [COMMIT_UNITS];
  commit_data_t            sel;
  logic                    accept;

  assign valid[COMMIT_ALU]         = alu_valid_i;
  assign valid[COMMIT_BRANCH]      = branch_valid_i;
  assign valid[COMMIT_CTRL_STATUS] = ctrl_status_valid_i;
  assign valid[COMMIT_MEM]         = mem_valid_i;

  assign results[COMMIT_ALU]         = alu_result;
  assign results[COMMIT_BRANCH]      = branch_result;
  assign results[COMMIT_CTRL_STATUS] = ctrl_status_result;
  assign results[COMMIT_MEM]         = mem_result;

  // No grant during reset or the flush pulse cycle; the pointer therefore holds too.
  hsv_core_commit_arbiter #(
    .N  (COMMIT_UNITS),
    .RR (RR_ARB)
  ) u_arbiter (
    .clk   (clk_core),
    .rst   (rst_core),
    .en    (!rst_core && !flush_req),
    .req   (valid),
    .grant (grant)
  );

  assign alu_ready_o         = grant[COMMIT_ALU];
  assign branch_ready_o      = grant[COMMIT_BRANCH];
  assign ctrl_status_ready_o = grant[COMMIT_CTRL_STATUS];
  assign mem_ready_o         = grant[COMMIT_MEM];
  assign accept              = |grant;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < COMMIT_UNITS; i++) begin
      if (grant[i]) sel = results[i];
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      commit_mask <= '0;
      retire      <= 1'b0;
      flush_req   <= 1'b0;
      flush_pc    <= '0;
    end else begin
      wr_en       <= accept && sel.writeback && (sel.rd_addr != '0);
      wr_addr     <= accept ? sel.rd_addr : '0;
      wr_data     <= accept ? XLEN'(sel.rd_value) : '0;
      commit_mask <= (accept && sel.writeback) ? (NUM_REGS'(1) << sel.rd_addr) : '0;
      retire      <= accept;
      flush_req   <= accept && sel.flush;
      if (accept && sel.flush) flush_pc <= XLEN'(sel.flush_pc);
    end
  end

endmodule

// File: tb/tb_hsv_core_commit.sv
// Scoreboard bench for hsv_core_commit: reference model predicts grants and writebacks, monitor checks registered outputs.
module tb_hsv_core_commit;
  import hsv_core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [3:0]   vld_in = '0;
  commit_data_t res_in [4];

  logic         rdy_alu, rdy_br, rdy_cs, rdy_mem;
  logic         wr_en, retire, flush_req;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data, commit_mask, flush_pc;

  logic         fp_rdy_alu, fp_rdy_br, fp_rdy_cs, fp_rdy_mem;
  logic         fp_wr_en, fp_retire, fp_flush_req;
  logic [4:0]   fp_wr_addr;
  logic [31:0]  fp_wr_data, fp_commit_mask, fp_flush_pc;

  hsv_core_commit #(.XLEN(32), .NUM_REGS(32), .RR_ARB(1)) dut (
    .clk_core(clk), .rst_core(rst),
    .alu_valid_i(vld_in[0]), .branch_valid_i(vld_in[1]),
    .ctrl_status_valid_i(vld_in[2]), .mem_valid_i(vld_in[3]),
    .alu_result(res_in[0]), .branch_result(res_in[1]),
    .ctrl_status_result(res_in[2]), .mem_result(res_in[3]),
    .alu_ready_o(rdy_alu), .branch_ready_o(rdy_br),
    .ctrl_status_ready_o(rdy_cs), .mem_ready_o(rdy_mem),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_mask(commit_mask), .retire(retire),
    .flush_req(flush_req), .flush_pc(flush_pc)
  );

  hsv_core_commit #(.XLEN(32), .NUM_REGS(32), .RR_ARB(0)) dut_fp (
    .clk_core(clk), .rst_core(rst),
    .alu_valid_i(vld_in[0]), .branch_valid_i(vld_in[1]),
    .ctrl_status_valid_i(vld_in[2]), .mem_valid_i(vld_in[3]),
    .alu_result(res_in[0]), .branch_result(res_in[1]),
    .ctrl_status_result(res_in[2]), .mem_result(res_in[3]),
    .alu_ready_o(fp_rdy_alu), .branch_ready_o(fp_rdy_br),
    .ctrl_status_ready_o(fp_rdy_cs), .mem_ready_o(fp_rdy_mem),
    .wr_en(fp_wr_en), .wr_addr(fp_wr_addr), .wr_data(fp_wr_data),
    .commit_mask(fp_commit_mask), .retire(fp_retire),
    .flush_req(fp_flush_req), .flush_pc(fp_flush_pc)
  );

  typedef struct {
    bit          is_rst;
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          wb;
    bit          fl;
    logic [31:0] fpc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state: pending requests per unit and who won last.
  logic [3:0]   pend = '0;
  commit_data_t pay [4];
  int           last = 3;
  int           acc_prev = -1;
  bit           flush_prev = 1'b0;
  bit           fp_flush = 1'b0;

  function automatic int rr_pick(input logic [3:0] v, input int after);
    for (int k = 1; k <= 4; k++) begin
      int u = (after + k) % 4;
      if (v[u]) return u;
    end
    return -1;
  endfunction

  function automatic int fp_pick(input logic [3:0] v);
    for (int u = 0; u < 4; u++) if (v[u]) return u;
    return -1;
  endfunction

  function automatic commit_data_t mk(input logic [4:0] rd, input logic [31:0] v,
                                      input bit wb, input bit fl, input logic [31:0] pc);
    commit_data_t d;
    d.rd_addr = rd; d.rd_value = v; d.writeback = wb; d.flush = fl; d.flush_pc = pc;
    return d;
  endfunction

  function automatic commit_data_t rand_pay();
    logic [4:0] rd;
    rd = ($urandom_range(9, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
    return mk(rd, $urandom, $urandom_range(9, 0) < 8, $urandom_range(9, 0) == 0, $urandom);
  endfunction

  task automatic cycle(input bit spawn, input bit rst_in);
    int g, fg;
    logic [3:0] rdy, fp_rdy, exp_rdy, exp_fp;
    @(posedge clk); #1;
    if (acc_prev >= 0) pend[acc_prev] = 1'b0;
    if (spawn && flush_prev)
      for (int u = 0; u < 4; u++) if ($urandom_range(1, 0) == 1) pend[u] = 1'b0;
    if (spawn)
      for (int u = 0; u < 4; u++)
        if (!pend[u] && $urandom_range(99, 0) < 40) begin
          pay[u] = rand_pay();
          pend[u] = 1'b1;
        end
    rst = rst_in;
    for (int u = 0; u < 4; u++) res_in[u] = pend[u] ? pay[u] : commit_data_t'($urandom);
    vld_in = pend;
    #1;
    g  = (rst_in || flush_prev) ? -1 : rr_pick(pend, last);
    fg = (rst_in || fp_flush) ? -1 : fp_pick(pend);
    exp_rdy = (g  >= 0) ? 4'(1 << g)  : 4'd0;
    exp_fp  = (fg >= 0) ? 4'(1 << fg) : 4'd0;
    rdy    = {rdy_mem, rdy_cs, rdy_br, rdy_alu};
    fp_rdy = {fp_rdy_mem, fp_rdy_cs, fp_rdy_br, fp_rdy_alu};
    chk("ready_rr", 64'(rdy), 64'(exp_rdy));
    chk("ready_fp", 64'(fp_rdy), 64'(exp_fp));
    fp_flush = (fg >= 0) && pay[fg].flush;
    if (rst_in) begin
      q.push_back('{is_rst: 1'b1, cyc: cyc, rd: '0, val: '0, wb: 1'b0, fl: 1'b0, fpc: '0});
      last = 3; acc_prev = -1; flush_prev = 1'b0;
    end else if (g >= 0) begin
      q.push_back('{is_rst: 1'b0, cyc: cyc, rd: pay[g].rd_addr, val: pay[g].rd_value,
                    wb: pay[g].writeback, fl: pay[g].flush, fpc: pay[g].flush_pc});
      last = g; acc_prev = g; flush_prev = pay[g].flush;
    end else begin
      acc_prev = -1; flush_prev = 1'b0;
    end
  endtask

  // Monitor: retires scoreboard entries one cycle after acceptance, otherwise expects idle outputs.
  logic [31:0] exp_fpc = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t it;
      while (q.size() > 0 && q[0].cyc < cyc - 1) begin
        it = q.pop_front();
        chk("missed_entry", 64'(it.cyc), 64'(cyc - 1));
      end
      if (q.size() > 0 && q[0].cyc == cyc - 1) begin
        it = q.pop_front();
        if (it.is_rst) begin
          exp_fpc = '0;
          chk("rst_strobes", {wr_en, retire, flush_req}, 0);
          chk("rst_mask", 64'(commit_mask), 0);
          chk("rst_addr_data", {wr_addr, wr_data}, 0);
          chk("rst_flush_pc", 64'(flush_pc), 0);
        end else begin
          if (it.fl) exp_fpc = it.fpc;
          chk("wr_en", 64'(wr_en), 64'(it.wb && it.rd != 0));
          if (it.wb && it.rd != 0) begin
            chk("wr_addr", 64'(wr_addr), 64'(it.rd));
            chk("wr_data", 64'(wr_data), 64'(it.val));
          end
          chk("commit_mask", 64'(commit_mask), it.wb ? 64'(32'd1 << it.rd) : 64'd0);
          chk("retire", 64'(retire), 1);
          chk("flush_req", 64'(flush_req), 64'(it.fl));
          chk("flush_pc", 64'(flush_pc), 64'(exp_fpc));
        end
      end else begin
        chk("idle_strobes", {wr_en, retire, flush_req}, 0);
        chk("idle_mask", 64'(commit_mask), 0);
        chk("idle_addr_data", {wr_addr, wr_data}, 0);
        chk("idle_flush_pc", 64'(flush_pc), 64'(exp_fpc));
      end
    end
  end

  initial begin
    for (int u = 0; u < 4; u++) begin
      pay[u] = '0;
      res_in[u] = '0;
    end
    cycle(0, 1);
    mon_en = 1'b1;
    cycle(0, 1);
    cycle(0, 0);

    pay[0] = mk(5'd5, 32'hDEADBEEF, 1, 0, 0); pend[0] = 1'b1;
    cycle(0, 0); cycle(0, 0);

    cycle(0, 1);
    pay[0] = mk(5'd10, 32'h1111_0000, 1, 0, 0);
    pay[1] = mk(5'd11, 32'h2222_0000, 1, 0, 0);
    pay[2] = mk(5'd12, 32'h3333_0000, 1, 0, 0);
    pay[3] = mk(5'd13, 32'h4444_0000, 1, 0, 0);
    pend = 4'hF;
    repeat (5) cycle(0, 0);

    pay[3] = mk(5'd0, 32'h5555_AAAA, 1, 0, 0); pend[3] = 1'b1;
    cycle(0, 0); cycle(0, 0);

    pay[0] = mk(5'd2, 32'h0000_0042, 1, 0, 0); pend[0] = 1'b1;
    cycle(0, 0);
    pay[0] = mk(5'd3, 32'h0000_0077, 1, 0, 0); pend[0] = 1'b1;
    pay[1] = mk(5'd1, 32'h0000_0104, 1, 1, 32'h200); pend[1] = 1'b1;
    cycle(0, 0);
    repeat (3) cycle(0, 0);

    pay[2] = mk(5'd7, 32'hC0DE_0007, 1, 0, 0); pend[2] = 1'b1;
    cycle(0, 1);
    pay[0] = mk(5'd8, 32'h0000_0008, 1, 0, 0); pend[0] = 1'b1;
    pay[3] = mk(5'd9, 32'h0000_0009, 1, 0, 0); pend[3] = 1'b1;
    repeat (5) cycle(0, 0);

    for (int n = 0; n < 3000; n++) cycle(1, $urandom_range(99, 0) == 0);

    pend = '0;
    repeat (3) cycle(0, 0);
    chk("drain", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
